// File: rtl/board_io_frontend_if.sv
// rtl/board_io_frontend_if.sv - signal bundle between board pins, design core and board_io_frontend
// Purpose: carries raw board inputs, the core output bus and the conditioned outputs as one port.
// Signals:
//   btn_raw      [N_BUTTONS]  raw asynchronous button levels (board -> frontend)
//   sw_raw       [N_SWITCHES] raw asynchronous switch levels (board -> frontend)
//   core_outputs [OUT_WIDTH]  design core output bus (core -> frontend)
//   core_reset                stretched active-high core reset (frontend -> core)
//   btn_level    [N_BUTTONS]  debounced button levels (frontend -> core)
//   btn_pulse    [N_BUTTONS]  one-cycle press pulses (frontend -> core)
//   sw_level     [N_SWITCHES] debounced switch levels (frontend -> core)
//   led          [N_LEDS]     registered LED drive (frontend -> board)
// Modports: master = board/core side, slave = board_io_frontend.
interface board_io_frontend_if #(
   parameter int N_BUTTONS  = 4,
   parameter int N_SWITCHES = 4,
   parameter int OUT_WIDTH  = 10,
   parameter int N_LEDS     = 8
);
   logic [N_BUTTONS-1:0]  btn_raw;
   logic [N_SWITCHES-1:0] sw_raw;
   logic [OUT_WIDTH-1:0]  core_outputs;
   logic                  core_reset;
   logic [N_BUTTONS-1:0]  btn_level;
   logic [N_BUTTONS-1:0]  btn_pulse;
   logic [N_SWITCHES-1:0] sw_level;
   logic [N_LEDS-1:0]     led;

   modport master (
      output btn_raw, sw_raw, core_outputs,
      input  core_reset, btn_level, btn_pulse, sw_level, led
   );

   modport slave (
      input  btn_raw, sw_raw, core_outputs,
      output core_reset, btn_level, btn_pulse, sw_level, led
   );
endinterface

// File: rtl/board_io_frontend.sv
// rtl/board_io_frontend.sv - synchroniser, debouncer, press pulser, core reset stretcher and LED register
// Purpose: reusable front end between raw board buttons/switches/LEDs and a design core.
// Ports:
//   clock  board clock, all logic on its rising edge
//   reset  synchronous active-high reset
//   io     board_io_frontend_if.slave (btn_raw, sw_raw, core_outputs in;
//          core_reset, btn_level, btn_pulse, sw_level, led out)
// Optional feature: BOARD_IO_FRONTEND_AUTOREPEAT_EN adds per-button auto-repeat pulses
//   (REPEAT_DELAY after the press pulse, then every REPEAT_PERIOD while held).
module board_io_frontend #(
   parameter int N_BUTTONS       = 4,
   parameter int N_SWITCHES      = 4,
   parameter int OUT_WIDTH       = 10,
   parameter int N_LEDS          = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int RESET_HOLD      = 16,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic               clock,
   input  logic               reset,
   board_io_frontend_if.slave io
);
   // Buttons occupy the low channels, switches the high channels; both debounce identically.
   localparam int N_CH = N_BUTTONS + N_SWITCHES;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam int HOLD_W = $clog2(RESET_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   logic [N_CH-1:0]      raw_all;
   logic [N_CH-1:0]      sync1_q, sync1_d;
   logic [N_CH-1:0]      sync2_q, sync2_d;
   logic [N_CH-1:0]      level_q, level_d;
   logic [CNT_W-1:0]     db_cnt_q [N_CH];
   logic [CNT_W-1:0]     db_cnt_d [N_CH];
   logic [N_BUTTONS-1:0] press;
   logic [N_BUTTONS-1:0] pulse_q, pulse_d;
   logic                 core_reset_q, core_reset_d;
   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [N_LEDS-1:0]    led_q, led_d;
   logic [OUT_WIDTH-1:0] core_bus;
   logic                 unused_core_bits;

   assign raw_all  = {io.sw_raw, io.btn_raw};
   assign core_bus = io.core_outputs;
   // Core bits above the LED count are intentionally dropped.
   assign unused_core_bits = ^core_bus;

   // Debounce: only the second synchroniser flop is examined. A channel commits
   // after DEBOUNCE_CYCLES consecutive samples that disagree with its level.
   always_comb begin
      sync1_d = raw_all;
      sync2_d = sync1_q;
      level_d = level_q;
      for (int i = 0; i < N_CH; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               level_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // A press is a 0->1 commit, visible on the same edge that updates the level.
   assign press = level_d[N_BUTTONS-1:0] & ~level_q[N_BUTTONS-1:0];

`ifdef BOARD_IO_FRONTEND_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W = $clog2(RPT_MAX + 1);
   localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0]     rpt_cnt_q [N_BUTTONS];
   logic [RPT_W-1:0]     rpt_cnt_d [N_BUTTONS];
   logic [N_BUTTONS-1:0] rpt_first_q, rpt_first_d;
   logic [N_BUTTONS-1:0] rpt_fire;

   // rpt_cnt counts cycles since the last pulse; rpt_first selects the initial
   // delay versus the steady repeat period. A release edge never fires.
   always_comb begin
      rpt_first_d = rpt_first_q;
      rpt_fire    = '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
         rpt_cnt_d[i] = '0;
         if (press[i]) begin
            rpt_first_d[i] = 1'b1;
         end else if (level_d[i] && level_q[i]) begin
            if (rpt_cnt_q[i] == (rpt_first_q[i] ? DLY_LAST : PER_LAST)) begin
               rpt_fire[i]    = 1'b1;
               rpt_first_d[i] = 1'b0;
            end else begin
               rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rpt_first_q <= '0;
         for (int i = 0; i < N_BUTTONS; i++) rpt_cnt_q[i] <= '0;
      end else begin
         rpt_first_q <= rpt_first_d;
         for (int i = 0; i < N_BUTTONS; i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
   end

   always_comb begin
      pulse_d = press | rpt_fire;
   end
`else
   localparam int UNUSED_RPT = REPEAT_DELAY + REPEAT_PERIOD;

   always_comb begin
      pulse_d = press;
   end
`endif

   // Core reset stays high for RESET_HOLD cycles after reset falls; reset restarts it.
   always_comb begin
      core_reset_d = core_reset_q;
      hold_cnt_d   = hold_cnt_q;
      if (core_reset_q) begin
         if (hold_cnt_q == HOLD_LAST) begin
            core_reset_d = 1'b0;
         end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
         end
      end
   end

   // LEDs stay dark while the core is held in reset.
   always_comb begin
      led_d = core_reset_q ? '0 : core_bus[N_LEDS-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         level_q      <= '0;
         pulse_q      <= '0;
         core_reset_q <= 1'b1;
         hold_cnt_q   <= '0;
         led_q        <= '0;
         for (int i = 0; i < N_CH; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         level_q      <= level_d;
         pulse_q      <= pulse_d;
         core_reset_q <= core_reset_d;
         hold_cnt_q   <= hold_cnt_d;
         led_q        <= led_d;
         for (int i = 0; i < N_CH; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign io.btn_level  = level_q[N_BUTTONS-1:0];
   assign io.sw_level   = level_q[N_CH-1:N_BUTTONS];
   assign io.btn_pulse  = pulse_q;
   assign io.core_reset = core_reset_q;
   assign io.led        = led_q;
endmodule

// File: tb/tb_board_io_frontend.sv
// tb/tb_board_io_frontend.sv - self-checking bench for board_io_frontend
module tb_board_io_frontend;
   localparam int NB  = 4;
   localparam int NS  = 4;
   localparam int OW  = 10;
   localparam int NL  = 8;
   localparam int DB  = 4;
   localparam int RH  = 8;
   localparam int RD  = 10;
   localparam int RP  = 5;
   localparam int NCH = NB + NS;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   board_io_frontend_if #(.N_BUTTONS(NB), .N_SWITCHES(NS), .OUT_WIDTH(OW), .N_LEDS(NL)) bus ();

   board_io_frontend #(
      .N_BUTTONS(NB), .N_SWITCHES(NS), .OUT_WIDTH(OW), .N_LEDS(NL),
      .DEBOUNCE_CYCLES(DB), .RESET_HOLD(RH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock),
      .reset(reset),
      .io(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 50)
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: raw inputs delayed two samples, a channel level follows the
   // sampled value once the last DB samples are identical and differ from it.
   bit            model_ok = 0;
   longint        ecount   = 0;
   longint        k;
   logic [NCH-1:0] m_d1, m_d2, m_samp, m_last, m_level;
   int            m_run [NCH];
   longint        m_press_t [NB];
   logic [NB-1:0] m_pulse;
   logic          m_cr;
   int            m_since;
   logic [NL-1:0] m_led;

   always @(posedge clock) begin
      ecount++;
      if (reset) begin
         model_ok = 1;
         m_d1 = '0; m_d2 = '0; m_last = '0; m_level = '0; m_pulse = '0;
         for (int c = 0; c < NCH; c++) m_run[c] = 0;
         for (int c = 0; c < NB; c++) m_press_t[c] = 0;
         m_cr = 1'b1; m_since = 0; m_led = '0;
      end else begin
         m_samp = m_d2;
         m_d2   = m_d1;
         m_d1   = {bus.sw_raw, bus.btn_raw};
         m_pulse = '0;
         for (int c = 0; c < NCH; c++) begin
            if (m_samp[c] == m_last[c]) m_run[c] = (m_run[c] < DB) ? m_run[c] + 1 : DB;
            else m_run[c] = 1;
            m_last[c] = m_samp[c];
            if (m_samp[c] != m_level[c] && m_run[c] >= DB) begin
               m_level[c] = m_samp[c];
               if (c < NB && m_samp[c]) begin
                  m_pulse[c]   = 1'b1;
                  m_press_t[c] = ecount;
               end
            end
         end
`ifdef BOARD_IO_FRONTEND_AUTOREPEAT_EN
         for (int c = 0; c < NB; c++) begin
            if (m_level[c] && !m_pulse[c]) begin
               k = ecount - m_press_t[c];
               if (k == RD || (k > RD && ((k - RD) % RP) == 0)) m_pulse[c] = 1'b1;
            end
         end
`endif
         m_led   = m_cr ? '0 : bus.core_outputs[NL-1:0];
         m_since = (m_since < RH) ? m_since + 1 : RH;
         m_cr    = (m_since < RH);
      end
   end

   always @(negedge clock) begin
      if (model_ok) begin
         check("btn_level",  bus.btn_level,  m_level[NB-1:0]);
         check("sw_level",   bus.sw_level,   m_level[NCH-1:NB]);
         check("btn_pulse",  bus.btn_pulse,  m_pulse);
         check("core_reset", bus.core_reset, m_cr);
         check("led",        bus.led,        m_led);
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic hold_check(input string name);
      for (int i = 0; i < RH; i++) begin
         @(negedge clock);
         check(name, bus.core_reset, 1'b1);
      end
      @(negedge clock);
      check(name, bus.core_reset, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [63:0] seen_rpt, exp_rpt;
   bit          found;

   initial begin
      reset = 1'b1;
      bus.btn_raw = '0;
      bus.sw_raw = '0;
      bus.core_outputs = '0;
      tick(); tick(); tick();
      check("rst_core_reset", bus.core_reset, 1'b1);
      check("rst_btn_level",  bus.btn_level, 0);
      check("rst_btn_pulse",  bus.btn_pulse, 0);
      check("rst_sw_level",   bus.sw_level, 0);
      check("rst_led",        bus.led, 0);
      reset = 1'b0;
      hold_check("hold_first");

      // Reassert reset part-way through a hold; a full hold follows.
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("hold_mid", bus.core_reset, 1'b1);
      end
      @(posedge clock); #2;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      hold_check("hold_restart");

      // Button press latency and single pulse.
      tick();
      bus.btn_raw[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         check("press_latency_lvl", bus.btn_level[0], 1'b0);
      end
      @(negedge clock);
      check("press_commit_lvl", bus.btn_level[0], 1'b1);
      check("press_pulse", bus.btn_pulse[0], 1'b1);
      @(negedge clock);
      check("press_pulse_end", bus.btn_pulse[0], 1'b0);

      // Three-sample glitch never commits.
      tick();
      bus.btn_raw[1] = 1'b1;
      tick(); tick(); tick();
      bus.btn_raw[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("glitch_lvl", bus.btn_level[1], 1'b0);
         check("glitch_pulse", bus.btn_pulse[1], 1'b0);
      end

      // Switches with a bounce on bit 0.
      tick();
      bus.sw_raw = 4'b1010;
      repeat (10) tick();
      check("sw_stable", bus.sw_level, 4'b1010);
      bus.sw_raw = 4'b0101;
      tick();
      bus.sw_raw = 4'b0100;
      tick();
      bus.sw_raw = 4'b0101;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clock);
         if (i == 4) check("sw_before", bus.sw_level, 4'b1010);
         if (i == 5) check("sw_hi_commit", bus.sw_level, 4'b0100);
         if (i == 6) check("sw_bit0_wait", bus.sw_level, 4'b0100);
         if (i == 7) check("sw_bit0_commit", bus.sw_level, 4'b0101);
      end

      // LED path.
      repeat (3) tick();
      bus.core_outputs = 10'h3A5;
      @(negedge clock);
      check("led_before", bus.led, 8'h00);
      @(negedge clock);
      check("led_a5", bus.led, 8'hA5);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.core_outputs = 10'h0FF;
      for (int i = 0; i < RH; i++) begin
         @(negedge clock);
         check("led_in_core_reset", bus.led, 8'h00);
      end
      @(negedge clock);
      check("led_release_cr", bus.core_reset, 1'b0);
      check("led_release_led", bus.led, 8'h00);
      @(negedge clock);
      check("led_ff", bus.led, 8'hFF);

      // Long hold on button 2: repeat pulses only with auto-repeat.
      tick();
      bus.btn_raw[2] = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clock);
         if (bus.btn_level[2]) found = 1;
      end
      check("rpt_commit_found", found, 1'b1);
      check("rpt_press_pulse", bus.btn_pulse[2], 1'b1);
      seen_rpt = '0;
      for (int off = 1; off <= 40; off++) begin
         @(negedge clock);
         if (bus.btn_pulse[2]) seen_rpt[off] = 1'b1;
         if (off == 22) bus.btn_raw[2] = 1'b0;
      end
`ifdef BOARD_IO_FRONTEND_AUTOREPEAT_EN
      exp_rpt = (64'd1 << 10) | (64'd1 << 15) | (64'd1 << 20) | (64'd1 << 25);
`else
      exp_rpt = 64'd0;
`endif
      check("rpt_pattern", seen_rpt, exp_rpt);
      check("rpt_released", bus.btn_level[2], 1'b0);

      // Randomised phase: alternating fast (glitchy) and slow (long hold) toggling.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         tick();
         for (int c = 0; c < NB; c++)
            if ($urandom_range(0, ((cyc / 500) % 2 == 1) ? 24 : 4) == 0) bus.btn_raw[c] = ~bus.btn_raw[c];
         for (int c = 0; c < NS; c++)
            if ($urandom_range(0, 5) == 0) bus.sw_raw[c] = ~bus.sw_raw[c];
         bus.core_outputs = OW'($urandom);
         if (reset) reset = ($urandom_range(0, 2) == 0);
         else reset = ($urandom_range(0, 299) == 0);
      end
      reset = 1'b0;
      repeat (5) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
